// File: rtl/multi_word_detector.sv
// Streaming matcher for up to NUM_WORDS programmable patterns of up to MAX_LEN characters.
// Emits a registered one-cycle found pulse per word and keeps a saturating match count.
module multi_word_detector #(
   parameter int unsigned NUM_WORDS = 3,
   parameter int unsigned MAX_LEN   = 8,
   parameter int unsigned CHAR_W    = 8,
   parameter int unsigned CNT_W     = 16,
   localparam int unsigned WordW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
   localparam int unsigned IdxW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
   localparam int unsigned LenW     = $clog2(MAX_LEN + 1)
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic [CHAR_W-1:0]    x_i,
   input  logic                 x_valid_i,
   input  logic                 load_en_i,
   input  logic                 len_en_i,
   input  logic [WordW-1:0]     load_word_i,
   input  logic [IdxW-1:0]      load_idx_i,
   input  logic [CHAR_W-1:0]    load_char_i,
   input  logic [LenW-1:0]      len_val_i,
   output logic [NUM_WORDS-1:0] wfound_o,
   output logic                 end_c_o,
   output logic [CNT_W-1:0]     match_count_o
);

   localparam int unsigned SumW = CNT_W + $clog2(NUM_WORDS + 1);
   localparam logic [SumW-1:0] CntMax = SumW'({CNT_W{1'b1}});

   logic [CHAR_W-1:0]    pat_q  [NUM_WORDS][MAX_LEN];
   logic [LenW-1:0]      len_q  [NUM_WORDS];
   logic [LenW-1:0]      len_d  [NUM_WORDS];
   logic [IdxW-1:0]      prog_q [NUM_WORDS];
   logic [IdxW-1:0]      prog_d [NUM_WORDS];
   logic [NUM_WORDS-1:0] wfound_q, wfound_d;
   logic [CNT_W-1:0]     match_count_q, match_count_d;

   logic                 cfg_write;
   logic                 word_ok, idx_ok;
   logic [SumW-1:0]      sum;

   assign cfg_write = load_en_i | len_en_i;
   assign word_ok   = int'(load_word_i) < int'(NUM_WORDS);
   assign idx_ok    = int'(load_idx_i) < int'(MAX_LEN);

   // Pattern RAM deliberately has no reset.
   always_ff @(posedge clock_i) begin
      if (load_en_i && word_ok && idx_ok) begin
         pat_q[load_word_i][load_idx_i] <= load_char_i;
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_WORDS; k++) begin
         len_d[k]    = len_q[k];
         prog_d[k]   = prog_q[k];
         wfound_d[k] = 1'b0;
         if (len_en_i && word_ok && (int'(load_word_i) == k)) begin
            len_d[k] = len_val_i;
         end
         if (cfg_write) begin
            prog_d[k] = '0;
         end else if (x_valid_i && (len_q[k] != '0) && (int'(len_q[k]) <= int'(MAX_LEN))) begin
            if (x_i == pat_q[k][prog_q[k]]) begin
               if (int'(prog_q[k]) == int'(len_q[k]) - 1) begin
                  wfound_d[k] = 1'b1;
                  prog_d[k]   = '0;
               end else begin
                  prog_d[k] = prog_q[k] + IdxW'(1);
               end
            end else if (x_i == pat_q[k][0]) begin
               // Restart only on the first character; no prefix-function fallback.
               if (len_q[k] == LenW'(1)) begin
                  wfound_d[k] = 1'b1;
                  prog_d[k]   = '0;
               end else begin
                  prog_d[k] = IdxW'(1);
               end
            end else begin
               prog_d[k] = '0;
            end
         end
      end
   end

   always_comb begin
      sum = SumW'(match_count_q);
      for (int k = 0; k < NUM_WORDS; k++) begin
         sum = sum + SumW'(wfound_d[k]);
      end
      match_count_d = (sum > CntMax) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wfound_q      <= '0;
         match_count_q <= '0;
         for (int k = 0; k < NUM_WORDS; k++) begin
            len_q[k]  <= '0;
            prog_q[k] <= '0;
         end
      end else begin
         wfound_q      <= wfound_d;
         match_count_q <= match_count_d;
         for (int k = 0; k < NUM_WORDS; k++) begin
            len_q[k]  <= len_d[k];
            prog_q[k] <= prog_d[k];
         end
      end
   end

   assign wfound_o      = wfound_q;
   assign end_c_o       = |wfound_q;
   assign match_count_o = match_count_q;

endmodule
